// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply controller driving an external combinational modmul.
// Latency: done pulses 2*ELEN+2 cycles after the accepting edge, for every exponent.
// Backpressure: none; start is honoured only in IDLE/DONE and is dropped (not queued) while busy.
module modexp_ctrl #(
    parameter int LEN  = 256,
    parameter int ELEN = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [LEN-1:0]  base,
    input  logic [ELEN-1:0] exp,
    input  logic [LEN-1:0]  n,
    input  logic [LEN-1:0]  n_prime,
    input  logic [LEN-1:0]  r2_mod_n,
    output logic            busy,
    output logic            done,
    output logic [LEN-1:0]  res,
    output logic [LEN-1:0]  mm_a,
    output logic [LEN-1:0]  mm_b,
    output logic [LEN-1:0]  mm_n,
    output logic [LEN-1:0]  mm_n_prime,
    output logic [LEN-1:0]  mm_r2,
    input  logic [LEN-1:0]  mm_res
);
    localparam int IW = (ELEN > 1) ? $clog2(ELEN) : 1;
    localparam logic [LEN-1:0] ONE = {{(LEN-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]  TOP = IW'(ELEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SQR,
        S_MUL,
        S_DONE
    } state_t;

    state_t          state;
    logic [LEN-1:0]  base_r;
    logic [ELEN-1:0] exp_r;
    logic [LEN-1:0]  n_r;
    logic [LEN-1:0]  n_prime_r;
    logic [LEN-1:0]  r2_r;
    logic [LEN-1:0]  base_red;
    logic [LEN-1:0]  acc;
    logic [IW-1:0]   idx;
    logic [LEN-1:0]  acc_mul;

    // The multiply is always issued; the exponent bit only selects whether it is kept.
    always_comb begin
        acc_mul = exp_r[idx] ? mm_res : acc;
    end

    assign mm_n       = n_r;
    assign mm_n_prime = n_prime_r;
    assign mm_r2      = r2_r;

    // mm_a/mm_b are registered, so each branch loads the operands of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            base_r    <= '0;
            exp_r     <= '0;
            n_r       <= '0;
            n_prime_r <= '0;
            r2_r      <= '0;
            base_red  <= '0;
            acc       <= '0;
            idx       <= '0;
            res       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mm_a      <= '0;
            mm_b      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    mm_a  <= '0;
                    mm_b  <= '0;
                    state <= S_IDLE;
                    if (start) begin
                        base_r    <= base;
                        exp_r     <= exp;
                        n_r       <= n;
                        n_prime_r <= n_prime;
                        r2_r      <= r2_mod_n;
                        busy      <= 1'b1;
                        mm_a      <= base;
                        mm_b      <= ONE;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    base_red <= mm_res;
                    acc      <= ONE;
                    idx      <= TOP;
                    mm_a     <= ONE;
                    mm_b     <= ONE;
                    state    <= S_SQR;
                end
                S_SQR: begin
                    acc   <= mm_res;
                    mm_a  <= mm_res;
                    mm_b  <= base_red;
                    state <= S_MUL;
                end
                S_MUL: begin
                    acc <= acc_mul;
                    if (idx != '0) begin
                        idx   <= idx - 1'b1;
                        mm_a  <= acc_mul;
                        mm_b  <= acc_mul;
                        state <= S_SQR;
                    end else begin
                        res   <= acc_mul;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        mm_a  <= '0;
                        mm_b  <= '0;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl with a behavioural a*b mod n multiplier and a plain-arithmetic power model.
module tb_modexp_ctrl;
    localparam int LEN  = 256;
    localparam int ELEN = 256;
    localparam int LAT  = 2 * ELEN + 2;
    localparam logic [LEN-1:0] P  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [LEN-1:0] NP = 256'hc9bd1905_15538399_9c46c2c2_95f2b761_bcb223fe_dc24a059_d838091d_d2253531;
    localparam logic [LEN-1:0] R2 = 256'h1_000007a2_000e90a1;
    localparam logic [LEN-1:0] FB = 256'hA1B2C3D4_E5F60718_293A4B5C_6D7E8F90_12345678_9ABCDEF0_FEDCBA98_12345678;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [LEN-1:0]  base;
    logic [ELEN-1:0] exp;
    logic [LEN-1:0]  n;
    logic [LEN-1:0]  n_prime;
    logic [LEN-1:0]  r2_mod_n;
    logic            busy;
    logic            done;
    logic [LEN-1:0]  res;
    logic [LEN-1:0]  mm_a;
    logic [LEN-1:0]  mm_b;
    logic [LEN-1:0]  mm_n;
    logic [LEN-1:0]  mm_n_prime;
    logic [LEN-1:0]  mm_r2;
    logic [LEN-1:0]  mm_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    modexp_ctrl #(.LEN(LEN), .ELEN(ELEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exp(exp), .n(n),
        .n_prime(n_prime), .r2_mod_n(r2_mod_n), .busy(busy), .done(done), .res(res),
        .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n), .mm_n_prime(mm_n_prime), .mm_r2(mm_r2),
        .mm_res(mm_res)
    );

    function automatic logic [LEN-1:0] mulmod(input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                                              input logic [LEN-1:0] m);
        logic [2*LEN-1:0] t;
        if (m == '0) return '0;
        t = {{LEN{1'b0}}, a} * {{LEN{1'b0}}, b};
        t = t % {{LEN{1'b0}}, m};
        return t[LEN-1:0];
    endfunction

    // Stand-in for the parent-level modmul: result valid in the same cycle.
    always_comb mm_res = mulmod(mm_a, mm_b, mm_n);

    // Right-to-left binary exponentiation, independent of the controller's schedule.
    function automatic logic [LEN-1:0] modpow(input logic [LEN-1:0] b, input logic [ELEN-1:0] e,
                                              input logic [LEN-1:0] m);
        logic [LEN-1:0] r;
        logic [LEN-1:0] sq;
        r  = mulmod(256'd1, 256'd1, m);
        sq = mulmod(b, 256'd1, m);
        for (int k = 0; k < ELEN; k++) begin
            if (e[k]) r = mulmod(r, sq, m);
            sq = mulmod(sq, sq, m);
        end
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_v(input string name, input logic [LEN-1:0] act, input logic [LEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Called at a negedge; returns right after the accepting posedge.
    task automatic accept(input logic [LEN-1:0] b, input logic [ELEN-1:0] e, input logic [LEN-1:0] m);
        base = b; exp = e; n = m; n_prime = NP; r2_mod_n = R2; start = 1'b1;
        @(posedge clk);
    endtask

    // cyc = cycle (counted from the accepting edge) in which done is seen, -1 on timeout.
    task automatic wait_done(output int cyc, output int bcnt, output logic busy_at_done);
        cyc = -1; bcnt = 0; busy_at_done = 1'bx;
        for (int c = 1; c <= LAT + 80; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) begin
                cyc = c;
                busy_at_done = busy;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    typedef struct {
        string           name;
        logic [LEN-1:0]  b;
        logic [ELEN-1:0] e;
        logic [LEN-1:0]  m;
        logic [LEN-1:0]  r;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl[NV];

    initial begin
        int cyc, bcnt, dcnt, dcyc;
        logic bad;
        logic [LEN-1:0] m;

        tbl[0] = '{"pow3_5",     256'd3, 256'd5,  P, 256'hF3};
        tbl[1] = '{"fermat2",    256'd2, P - 1,   P, 256'd1};
        tbl[2] = '{"fermatA1",   FB,     P - 1,   P, 256'd1};
        tbl[3] = '{"exp0",       256'd7, 256'd0,  P, 256'd1};
        tbl[4] = '{"base_gt_n",  P + 2,  256'd3,  P, 256'd8};
        tbl[5] = '{"base_eq_n",  P,      256'd9,  P, 256'd0};
        for (int k = 6; k < NV; k++) begin
            m = rand256() | 256'd1;
            m[LEN-1] = 1'b1;
            tbl[k].name = $sformatf("rand%0d", k);
            tbl[k].b = rand256();
            tbl[k].e = (k % 2 == 0) ? rand256() : (rand256() >> $urandom_range(0, 250));
            tbl[k].m = m;
            tbl[k].r = modpow(tbl[k].b, tbl[k].e, m);
        end

        rst_n = 1'b0; start = 1'b0; base = '0; exp = '0; n = '0; n_prime = '0; r2_mod_n = '0;
        repeat (2) @(negedge clk);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_done", int'(done), 0);
        chk_v("rst_res", res, '0);
        chk_v("rst_mm_a", mm_a, '0);
        chk_v("rst_mm_b", mm_b, '0);
        chk_v("rst_mm_n", mm_n, '0);
        chk_v("rst_mm_np", mm_n_prime, '0);
        chk_v("rst_mm_r2", mm_r2, '0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < NV; k++) begin
            accept(tbl[k].b, tbl[k].e, tbl[k].m);
            wait_done(cyc, bcnt, bad);
            chk_i({tbl[k].name, "_lat"}, cyc, LAT);
            chk_v({tbl[k].name, "_res"}, res, tbl[k].r);
            if (k < 2) begin
                chk_i({tbl[k].name, "_busycyc"}, bcnt, LAT - 1);
                chk_i({tbl[k].name, "_busy_in_done"}, int'(bad), 0);
                chk_v({tbl[k].name, "_mm_np"}, mm_n_prime, NP);
                chk_v({tbl[k].name, "_mm_r2"}, mm_r2, R2);
            end
            @(negedge clk);
            chk_i({tbl[k].name, "_done_1cyc"}, int'(done), 0);
        end

        // start pulse with new operands in cycle 100 must be dropped
        accept(256'd3, 256'd5, P);
        dcnt = 0; dcyc = -1;
        for (int c = 1; c <= LAT + 80; c++) begin
            @(negedge clk);
            if (done) begin dcnt++; dcyc = c; end
            start = (c == 99);
            if (c == 99) begin base = 256'd5; n = P - 2; end
        end
        chk_i("ign_done_cnt", dcnt, 1);
        chk_i("ign_done_cyc", dcyc, LAT);
        chk_v("ign_res", res, 256'hF3);

        // back-to-back: restart during the DONE cycle
        @(negedge clk);
        accept(256'd3, 256'd5, P);
        wait_done(cyc, bcnt, bad);
        chk_i("b2b_lat1", cyc, LAT);
        chk_v("b2b_res1", res, 256'hF3);
        accept(256'd2, 256'd10, P);
        wait_done(cyc, bcnt, bad);
        chk_i("b2b_lat2", cyc, LAT);
        chk_i("b2b_no_idle", bcnt, LAT - 1);
        chk_v("b2b_res2", res, 256'h400);

        // asynchronous reset in the middle of a job
        @(negedge clk);
        accept(256'd3, 256'd5, P);
        dcnt = 0;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dcnt++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_i("mrst_busy", int'(busy), 0);
        chk_i("mrst_done", int'(done), 0);
        chk_v("mrst_res", res, '0);
        chk_v("mrst_mm_a", mm_a, '0);
        chk_v("mrst_mm_b", mm_b, '0);
        chk_v("mrst_mm_n", mm_n, '0);
        chk_v("mrst_mm_np", mm_n_prime, '0);
        chk_v("mrst_mm_r2", mm_r2, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk_i("mrst_no_done", dcnt, 0);
        accept(256'd3, 256'd5, P);
        wait_done(cyc, bcnt, bad);
        chk_i("mrst_lat", cyc, LAT);
        chk_v("mrst_res_after", res, 256'hF3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
